// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared read-FSM encodings and clog2 helper
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } rd_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_read_streamer_if.sv
// rtl/fifo_read_streamer_if.sv - FIFO read port and output stream bundle
interface fifo_read_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    // Streamer side: drives the read strobe and the outgoing stream
    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last
    );

    // Environment side: the FIFO plus the downstream consumer
    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/stream_out_buf.sv
// rtl/stream_out_buf.sv - circular output buffer with valid/ready head
module stream_out_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                         clkb,
    input  logic                         reset_n,
    input  logic                         i_wr_en,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [clog2(BUF_DEPTH):0]    o_occupancy,
    output logic [clog2(BUF_DEPTH):0]    o_occ_next
);
    localparam int PTR_W = clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_occ;
    logic [PTR_W:0]        w_occ_next;
    logic                  w_pop;

    // Head is presented straight from registered state; writes never exceed credit
    assign o_valid     = (r_occ != '0);
    assign o_data      = r_mem[r_rd_ptr];
    assign w_pop       = o_valid & i_ready;
    assign o_occupancy = r_occ;
    assign o_occ_next  = w_occ_next;

    // Occupancy update: capture and pop together leave it unchanged
    always_comb begin
        w_occ_next = r_occ;
        case ({i_wr_en, w_pop})
            2'b10:   w_occ_next = r_occ + OCC_ONE;
            2'b01:   w_occ_next = r_occ - OCC_ONE;
            default: w_occ_next = r_occ;
        endcase
    end

    // Storage and pointers; reset drops all buffered words immediately
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_occ <= w_occ_next;
        end
    end
endmodule

// File: rtl/fifo_read_streamer.sv
// rtl/fifo_read_streamer.sv - paced FIFO reader feeding a framed valid/ready stream
module fifo_read_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int RD_GAP     = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clkb,
    input  logic                 reset_n,
    input  logic                 enable,
    fifo_read_streamer_if.master bus,
    output logic [15:0]          words_out,
    output logic                 busy
);
    localparam int               OCC_W    = clog2(BUF_DEPTH) + 1;
    localparam logic [7:0]       LAST_IDX = 8'(BURST_LEN - 1);
    localparam logic [2:0]       GAP_LOAD = (RD_GAP > 1) ? 3'(RD_GAP - 2) : 3'd0;

    rd_state_t             r_state;
    rd_state_t             w_next_state;
    logic [2:0]            r_gap_cnt;
    logic [RD_LATENCY-1:0] r_lat_sr;
    logic [RD_LATENCY-1:0] w_lat_sr_next;
    logic [2:0]            w_inflight;
    logic [OCC_W-1:0]      w_occupancy;
    logic [OCC_W-1:0]      w_occ_next;
    logic                  w_rd_en;
    logic                  w_capture;
    logic                  w_credit_ok;
    logic                  w_valid;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_data;
    logic [7:0]            r_burst_idx;
    logic [15:0]           r_words_out;
    logic                  r_busy;

    // Words whose strobe has been sampled but not yet captured
    assign w_inflight    = 3'($countones(r_lat_sr));
    assign w_capture     = r_lat_sr[RD_LATENCY-1];
    assign w_lat_sr_next = (r_lat_sr << 1) | RD_LATENCY'(w_rd_en);
    assign w_credit_ok   = (int'(w_occupancy) + int'(w_inflight)) < BUF_DEPTH;
    assign w_xfer        = w_valid & bus.m_ready;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_data;
    assign bus.m_last     = w_valid & (r_burst_idx == LAST_IDX);
    assign words_out      = r_words_out;
    assign busy           = r_busy;

    stream_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clkb        (clkb),
        .reset_n     (reset_n),
        .i_wr_en     (w_capture),
        .i_wr_data   (bus.fifo_rdata),
        .i_ready     (bus.m_ready),
        .o_valid     (w_valid),
        .o_data      (w_data),
        .o_occupancy (w_occupancy),
        .o_occ_next  (w_occ_next)
    );

    // Read FSM state register
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Read FSM next state: the flag is only evaluated in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && !bus.fifo_empty && w_credit_ok) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                w_next_state = (RD_GAP > 1) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (r_gap_cnt == 3'd0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Read FSM outputs: one strobe per REQ visit
    always_comb begin
        w_rd_en = 1'b0;
        if (r_state == ST_REQ) begin
            w_rd_en = 1'b1;
        end
    end

    // Gap down-counter: loaded in REQ so GAP lasts RD_GAP-1 cycles
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= 3'd0;
        end else if (r_state == ST_REQ) begin
            r_gap_cnt <= GAP_LOAD;
        end else if (r_state == ST_GAP && r_gap_cnt != 3'd0) begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
        end
    end

    // Latency pipeline of issued strobes; the top bit marks a capture edge
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_sr <= '0;
        end else begin
            r_lat_sr <= w_lat_sr_next;
        end
    end

    // Burst beat index and delivered-word counter advance on each transfer
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_idx <= 8'd0;
            r_words_out <= 16'd0;
        end else if (w_xfer) begin
            r_burst_idx <= (r_burst_idx == LAST_IDX) ? 8'd0 : r_burst_idx + 8'd1;
            r_words_out <= r_words_out + 16'd1;
        end
    end

    // Busy registered from the next-cycle in-flight and buffer state
    always_ff @(posedge clkb or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_lat_sr_next != '0) | (w_occ_next != '0);
        end
    end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb/tb_fifo_read_streamer.sv - directed self-checking bench for fifo_read_streamer
module tb_fifo_read_streamer;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic        clkb = 1'b1;
    logic        reset_n;
    logic        enable;
    logic [15:0] words_out;
    logic        busy;

    fifo_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_read_streamer #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (RD_LAT),
        .RD_GAP     (2),
        .BUF_DEPTH  (4),
        .BURST_LEN  (4)
    ) dut (
        .clkb      (clkb),
        .reset_n   (reset_n),
        .enable    (enable),
        .bus       (bus),
        .words_out (words_out),
        .busy      (busy)
    );

    always #5 clkb = ~clkb;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_count = 0;
    int underflow = 0;
    int last_count = 0;
    logic [7:0] fq[$];
    int         rd_cyc_q[$];
    logic [7:0] rx_q[$];
    logic       rx_last_q[$];
    logic [7:0] pipe [RD_LAT+1];

    // FIFO model with fixed read latency plus stream monitor, mid-cycle
    always @(negedge clkb) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            for (int k = 0; k <= RD_LAT; k++) pipe[k] = 8'h00;
        end else begin
            for (int k = RD_LAT; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = 8'h00;
            if (bus.fifo_rd_en) begin
                rd_count = rd_count + 1;
                rd_cyc_q.push_back(cyc);
                if (fq.size() == 0) underflow = underflow + 1;
                else pipe[0] = fq.pop_front();
            end
            if (bus.m_valid && bus.m_ready) begin
                rx_q.push_back(bus.m_data);
                rx_last_q.push_back(bus.m_last);
                if (bus.m_last) last_count = last_count + 1;
            end
        end
        bus.fifo_rdata = pipe[RD_LAT];
        bus.fifo_empty = (fq.size() == 0);
    end

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_last_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) tick();
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (words_out !== 16'h0000) begin errors++; $display("FAIL reset_words_out: got %h want 0000", words_out); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_stream();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        clear_logs();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(exp_d[i]);
        repeat (40) tick();
        checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (((i < rx_q.size()) ? rx_q[i] : 8'hxx) !== exp_d[i] ||
                ((i < rx_last_q.size()) ? rx_last_q[i] : 1'bx) !== exp_l[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx,
                         (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx, exp_d[i], exp_l[i]);
            end
        end
        checks++; if (rd_cyc_q.size() !== 4) begin errors++; $display("FAIL basic_strobes: got %0d want 4", rd_cyc_q.size()); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i >= rd_cyc_q.size() || rd_cyc_q[i] - rd_cyc_q[i-1] != 3) begin
                errors++;
                $display("FAIL basic_spacing%0d: got %0d want 3", i,
                         (i < rd_cyc_q.size()) ? rd_cyc_q[i] - rd_cyc_q[i-1] : -1);
            end
        end
        checks++; if (words_out !== 16'd4) begin errors++; $display("FAIL basic_words_out: got %0d want 4", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic       exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int  base;
        bit  seen;
        bit  hold_bad;
        clear_logs();
        base = rd_count;
        seen = 1'b0;
        hold_bad = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(exp_d[i]);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.m_valid === 1'b1) seen = 1'b1;
            if (seen && (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11)) hold_bad = 1'b1;
        end
        checks++; if (rd_count - base != 4) begin errors++; $display("FAIL bp_strobes: got %0d want 4", rd_count - base); end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11) begin errors++; $display("FAIL bp_head: got %b/%h want 1/11", bus.m_valid, bus.m_data); end
        checks++; if (!seen || hold_bad) begin errors++; $display("FAIL bp_hold: got seen=%b unstable=%b want seen=1 unstable=0", seen, hold_bad); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
        bus.m_ready = 1'b1;
        repeat (60) tick();
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (((i < rx_q.size()) ? rx_q[i] : 8'hxx) !== exp_d[i] ||
                ((i < rx_last_q.size()) ? rx_last_q[i] : 1'bx) !== exp_l[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx,
                         (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx, exp_d[i], exp_l[i]);
            end
        end
        checks++; if (words_out !== 16'd10) begin errors++; $display("FAIL bp_words_out: got %0d want 10", words_out); end
    endtask

    task automatic test_empty_fifo();
        int  base;
        bit  strobe_seen;
        base = rd_count;
        strobe_seen = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.fifo_rd_en !== 1'b0) strobe_seen = 1'b1;
        end
        checks++; if (strobe_seen || rd_count != base) begin errors++; $display("FAIL empty_strobes: got %0d want 0", rd_count - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b want 0", busy); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b want 0", bus.m_valid); end
    endtask

    task automatic test_enable_drop();
        int  base;
        bit  got_strobe;
        clear_logs();
        base = rd_count;
        got_strobe = 1'b0;
        bus.m_ready = 1'b1;
        enable = 1'b1;
        fq.push_back(8'hB1);
        fq.push_back(8'hB2);
        fq.push_back(8'hB3);
        for (int c = 0; c < 30 && !got_strobe; c++) begin
            tick();
            if (rd_count != base) got_strobe = 1'b1;
        end
        enable = 1'b0;
        checks++; if (!got_strobe) begin errors++; $display("FAIL drop_first_strobe: got none want 1 within 30 cycles"); end
        repeat (30) tick();
        checks++; if (rd_count - base != 1) begin errors++; $display("FAIL drop_strobes: got %0d want 1", rd_count - base); end
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hB1) begin errors++; $display("FAIL drop_word: got n=%0d want one beat B1", rx_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
        checks++; if (words_out !== 16'd11) begin errors++; $display("FAIL drop_words_out: got %0d want 11", words_out); end
        fq.delete();
    endtask

    task automatic test_reset_midop();
        logic [7:0] exp_d [4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int  base;
        bit  reached;
        clear_logs();
        base = rd_count;
        reached = 1'b0;
        bus.m_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'hC1 + 8'(i));
        for (int c = 0; c < 60 && !reached; c++) begin
            tick();
            if (rd_count - base == 4) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL rst_fill: got %0d strobes want 4 within 60 cycles", rd_count - base); end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hC1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_state: got valid=%b data=%h busy=%b want 1/C1/1", bus.m_valid, bus.m_data, busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL rst_async_words: got %0d want 0", words_out); end
        fq.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        clear_logs();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(exp_d[i]);
        repeat (40) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (((i < rx_q.size()) ? rx_q[i] : 8'hxx) !== exp_d[i] ||
                ((i < rx_last_q.size()) ? rx_last_q[i] : 1'bx) !== exp_l[i]) begin
                errors++;
                $display("FAIL rst_after_beat%0d: got %h/%b want %h/%b", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx,
                         (i < rx_last_q.size()) ? rx_last_q[i] : 1'bx, exp_d[i], exp_l[i]);
            end
        end
        checks++; if (words_out !== 16'd4) begin errors++; $display("FAIL rst_after_words: got %0d want 4", words_out); end
    endtask

    task automatic test_words_wrap();
        logic [15:0] wo_seen[$];
        logic [15:0] prev;
        bit          reached;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        clear_logs();
        last_count = 0;
        reached = 1'b0;
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 65534; i++) fq.push_back(8'(i));
        for (int c = 0; c < 65534 * 3 + 200 && !reached; c++) begin
            tick();
            if (words_out === 16'hFFFE) reached = 1'b1;
        end
        repeat (10) tick();
        checks++; if (!reached || words_out !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h want FFFE", words_out); end
        checks++; if (last_count != 16383) begin errors++; $display("FAIL wrap_last_cadence: got %0d want 16383", last_count); end
        clear_logs();
        prev = words_out;
        fq.push_back(8'hE1);
        fq.push_back(8'hE2);
        fq.push_back(8'hE3);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (words_out !== prev) begin
                wo_seen.push_back(words_out);
                prev = words_out;
            end
        end
        checks++; if (wo_seen.size() !== 3 || wo_seen[0] !== 16'hFFFF || wo_seen[1] !== 16'h0000 || wo_seen[2] !== 16'h0001) begin
            errors++; $display("FAIL wrap_sequence: got n=%0d last=%h want FFFF,0000,0001", wo_seen.size(), words_out); end
        checks++; if (rx_last_q.size() !== 3 || rx_last_q[0] !== 1'b0 || rx_last_q[1] !== 1'b1 || rx_last_q[2] !== 1'b0) begin
            errors++; $display("FAIL wrap_last_flags: got n=%0d want 0,1,0", rx_last_q.size()); end
        checks++; if (rx_q.size() !== 3 || rx_q[0] !== 8'hE1 || rx_q[2] !== 8'hE3) begin
            errors++; $display("FAIL wrap_data: got n=%0d want E1,E2,E3", rx_q.size()); end
    endtask

    task automatic test_no_underflow();
        checks++; if (underflow != 0) begin errors++; $display("FAIL no_underflow: got %0d strobes on empty FIFO want 0", underflow); end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_empty_fifo();
        test_enable_drop();
        test_reset_midop();
        test_words_wrap();
        test_no_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
